// File: rtl/carregador_matrizes.sv
// Operand loader for the 5x5 int8 matrix adder: fetches A then B from word memory
// and unpacks the row-major n x n bytes into zero-padded 5x5 operand buses.
module carregador_matrizes #(
   parameter int unsigned ADDR_W             = 16,
   parameter int unsigned BYTES_POR_PALAVRA  = 4,
   localparam int unsigned DATA_W            = 8 * BYTES_POR_PALAVRA
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        tamanho,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [199:0]      matrizA,
   output logic [199:0]      matrizB,
   output logic              busy,
   output logic              done,
   output logic              erro
);

   localparam int unsigned MAT_W = 200;
   localparam int unsigned IDX_W = 5;

   typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, FIM} estado_t;

   estado_t           estado, estado_n;
   logic [2:0]        tam_q, tam_n;
   logic [ADDR_W-1:0] base_a_q, base_a_n, base_b_q, base_b_n, mem_addr_n;
   logic [IDX_W-1:0]  palavra_q, palavra_n, elem_q, elem_n, elem_v;
   logic [IDX_W-1:0]  n_elem, n_palavras, pos_v;
   logic [2:0]        lin_q, lin_n, col_q, col_n, lin_v, col_v, col_inc;
   logic              erro_pend_q, erro_pend_n;
   logic              mem_rd_n, busy_n, done_n, erro_n;
   logic [MAT_W-1:0]  mat_a_n, mat_b_n;
   logic [7:0]        byte_v;

   assign n_elem     = IDX_W'(tam_q) * IDX_W'(tam_q);
   assign n_palavras = IDX_W'((32'(n_elem) + BYTES_POR_PALAVRA - 1) / BYTES_POR_PALAVRA);

   // Next-state, unpacking and next registered-output values
   always_comb begin
      estado_n    = estado;
      tam_n       = tam_q;
      base_a_n    = base_a_q;
      base_b_n    = base_b_q;
      palavra_n   = palavra_q;
      elem_n      = elem_q;
      lin_n       = lin_q;
      col_n       = col_q;
      erro_pend_n = erro_pend_q;
      mat_a_n     = matrizA;
      mat_b_n     = matrizB;
      elem_v      = elem_q;
      lin_v       = lin_q;
      col_v       = col_q;
      col_inc     = '0;
      pos_v       = '0;
      byte_v      = '0;

      case (estado)
         IDLE: begin
            if (start) begin
               tam_n     = tamanho;
               base_a_n  = base_a;
               base_b_n  = base_b;
               mat_a_n   = '0;
               mat_b_n   = '0;
               palavra_n = '0;
               elem_n    = '0;
               lin_n     = '0;
               col_n     = '0;
               if (tamanho >= 3'd2 && tamanho <= 3'd5) begin
                  estado_n    = REQ_A;
                  erro_pend_n = 1'b0;
               end else begin
                  estado_n    = FIM;
                  erro_pend_n = 1'b1;
               end
            end
         end
         REQ_A: estado_n = WAIT_A;
         REQ_B: estado_n = WAIT_B;
         WAIT_A, WAIT_B: begin
            if (mem_rvalid) begin
               // Lanes past the last element are dropped; row/col advance per kept lane
               for (int j = 0; j < int'(BYTES_POR_PALAVRA); j++) begin
                  if (elem_v < n_elem) begin
                     byte_v = mem_rdata[8*j +: 8];
                     pos_v  = IDX_W'(lin_v) * IDX_W'(5) + IDX_W'(col_v);
                     if (estado == WAIT_A) mat_a_n[{pos_v, 3'b000} +: 8] = byte_v;
                     else                  mat_b_n[{pos_v, 3'b000} +: 8] = byte_v;
                     elem_v  = IDX_W'(elem_v + IDX_W'(1));
                     col_inc = 3'(col_v + 3'd1);
                     if (col_inc == tam_q) begin
                        col_v = '0;
                        lin_v = 3'(lin_v + 3'd1);
                     end else begin
                        col_v = col_inc;
                     end
                  end
               end
               if (palavra_q == IDX_W'(n_palavras - IDX_W'(1))) begin
                  palavra_n = '0;
                  elem_n    = '0;
                  lin_n     = '0;
                  col_n     = '0;
                  estado_n  = (estado == WAIT_A) ? REQ_B : FIM;
               end else begin
                  palavra_n = IDX_W'(palavra_q + IDX_W'(1));
                  elem_n    = elem_v;
                  lin_n     = lin_v;
                  col_n     = col_v;
                  estado_n  = (estado == WAIT_A) ? REQ_A : REQ_B;
               end
            end
         end
         FIM:     estado_n = IDLE;
         default: estado_n = IDLE;
      endcase

      mem_rd_n   = (estado_n == REQ_A) || (estado_n == REQ_B);
      mem_addr_n = mem_addr;
      if (estado_n == REQ_A)      mem_addr_n = ADDR_W'(base_a_n + ADDR_W'(palavra_n));
      else if (estado_n == REQ_B) mem_addr_n = ADDR_W'(base_b_n + ADDR_W'(palavra_n));
      busy_n = (estado_n != IDLE) && (estado_n != FIM);
      done_n = (estado_n == FIM);
      erro_n = done_n && erro_pend_n;
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado      <= IDLE;
         tam_q       <= '0;
         base_a_q    <= '0;
         base_b_q    <= '0;
         palavra_q   <= '0;
         elem_q      <= '0;
         lin_q       <= '0;
         col_q       <= '0;
         erro_pend_q <= 1'b0;
         matrizA     <= '0;
         matrizB     <= '0;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         erro        <= 1'b0;
      end else begin
         estado      <= estado_n;
         tam_q       <= tam_n;
         base_a_q    <= base_a_n;
         base_b_q    <= base_b_n;
         palavra_q   <= palavra_n;
         elem_q      <= elem_n;
         lin_q       <= lin_n;
         col_q       <= col_n;
         erro_pend_q <= erro_pend_n;
         matrizA     <= mat_a_n;
         matrizB     <= mat_b_n;
         mem_rd      <= mem_rd_n;
         mem_addr    <= mem_addr_n;
         busy        <= busy_n;
         done        <= done_n;
         erro        <= erro_n;
      end
   end

endmodule

// File: doc/carregador_matrizes.md
Name: carregador_matrizes

Overview:
- Sequential operand loader directly upstream of the 5x5 int8 matrix adder.
- On start, reads matrix A, then matrix B, from word-addressed memory via a single-outstanding read handshake.
- Unpacks the packed row-major n×n bytes (n = 2..5) into zero-padded 200-bit 5x5 operand buses, element (r,c) at bits [(r*5+c)*8 +: 8].
- Holds both buses stable for the adder and pulses done.

Parameters:
- ADDR_W, 16, word address width.
- BYTES_POR_PALAVRA, 4, bytes per memory word; DATA_W = 8*BYTES_POR_PALAVRA.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  load request; sampled only in IDLE.
- tamanho  in  3  matrix dimension n; valid 2..5.
- base_a  in  ADDR_W  word address of first word of A.
- base_b  in  ADDR_W  word address of first word of B.
- mem_rd  out  1  read request strobe, one cycle per word.
- mem_addr  out  ADDR_W  read word address, valid while mem_rd = 1.
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid.
- mem_rvalid  in  1  read data valid; latency ≥1 cycle after mem_rd.
- matrizA  out  200  unpacked operand A to the adder.
- matrizB  out  200  unpacked operand B to the adder.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- erro  out  1  one-cycle pulse with done when tamanho is invalid.

Behaviour:
- One clock domain (clock). reset_n is synchronous, active-low.
- Reset (reset_n = 0 at a clock edge) forces:
  - FSM to IDLE;
  - matrizA, matrizB, mem_addr to 0;
  - mem_rd, busy, done, erro to 0;
  - internal counters to 0.
- Reset mid-load aborts immediately; any late mem_rvalid after reset is ignored.
- FSM states: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, FIM.
- IDLE:
  - start = 1 latches tamanho, base_a, base_b;
  - clears matrizA and matrizB to 0 and sets busy;
  - next state REQ_A if n ∈ 2..5, else FIM with erro pending.
- start while busy is ignored.
- Word count W = ceil(n*n / BYTES_POR_PALAVRA): n=2→1, 3→3, 4→4, 5→7 (at 4 bytes per word).
- REQ_x: mem_rd = 1 for exactly one cycle, mem_addr = base_x + word_idx; next WAIT_x.
- WAIT_x:
  - mem_rd = 0.
  - On mem_rvalid = 1, byte lane j (mem_rdata[8j +: 8], little-endian) becomes element index k = word_idx*BYTES_POR_PALAVRA + j, for each j with k < n*n.
  - Element k maps to row r = k / n, col c = k % n, and is written to bits [(r*5+c)*8 +: 8].
  - Lanes with k ≥ n*n are discarded. Positions with r ≥ n or c ≥ n remain 0.
  - If word_idx = W−1: word_idx ← 0, next REQ_B (from A) or FIM (from B). Else word_idx+1, next REQ_x.
- mem_rvalid outside WAIT_A/WAIT_B is ignored. Exactly one request is outstanding at any time.
- FIM:
  - done = 1 for one cycle; erro = 1 in the same cycle if tamanho was invalid;
  - busy drops to 0 in the same cycle as done;
  - next IDLE.
- For an invalid tamanho, matrizA/matrizB stay 0 and no memory requests are issued.
- Latency with memory latency L: start accepted at cycle t; first mem_rd at t+1; each word costs 1+L cycles; done at t+1+2W(1+L).
- matrizA/matrizB change only during loading. They hold their values from done until the next accepted start, so the combinational adder output is stable while busy = 0.
- No arithmetic on element data; values are passed through bit-exact (signed int8 opaque).

Test Plan:
- Reset check: hold reset_n = 0 for 3 cycles with start = 1 and mem_rvalid = 1 → all outputs 0, no mem_rd; release → IDLE, busy = 0.
- n = 5 load, L = 1:
  - Stimulus: base_a = 0x0010, base_b = 0x0020; memory byte k of A = k+1, of B = 0x80+k.
  - Required: 7 reads at 0x10..0x16, then 7 at 0x20..0x26.
  - Required: matrizA[7:0] = 0x01, matrizA[199:192] = 0x19; matrizB[199:192] = 0x98.
  - Required: done at cycle t+29; last-word lanes 1..3 discarded.
- n = 3 load, L = 3:
  - Stimulus: A bytes 0x11..0x19.
  - Required: (1,0) = 0x14 at bits [47:40]; (2,2) = 0x19 at bits [103:96].
  - Required: bits [39:24], rows 3..4 and cols 3..4 all 0.
  - Required: 3 reads per matrix; done at t+1+6·4 = t+25.
- Invalid size:
  - Stimulus: tamanho = 6 or tamanho = 1.
  - Required: no mem_rd; done and erro both pulse at t+1; matrices remain 0.
- Ignore cases:
  - Stimulus: start re-pulsed while busy, and a spurious mem_rvalid while in REQ_A.
  - Required: no restart and no data corruption; results identical to the clean n = 5 run.
- Abort mid-load: assert reset_n = 0 during WAIT_B, then issue a fresh n = 2 start → clean n = 2 result, 1 read per matrix, done at t+1+2(1+L).
